// File: rtl/peregrine_iram1_arb_if.sv
// Bus bundle between the IRAM1 arbiter, its two requesters (core IRAM1 port
// and DMA/preload port) and the single-port IRAM1 wrapper.
//   Core side : CoreEn/CoreWr/CoreAddr/CoreWrData/CoreLoadStore -> CoreBusy/CoreData
//   DMA side  : DmaReq/DmaWr/DmaAddr/DmaWrData -> DmaGnt/DmaRdValid/DmaRdData
//   Memory    : IRam1Addr/IRam1En/IRam1Wr/IRam1WrData/IRam1LoadStore <- IRam1Data
// slave  = arbiter view, master = environment view (requesters + memory).
interface peregrine_iram1_arb_if #(
  parameter int AW = 17,
  parameter int DW = 32
);
  logic          CoreEn;
  logic          CoreWr;
  logic [AW-1:0] CoreAddr;
  logic [DW-1:0] CoreWrData;
  logic          CoreLoadStore;
  logic          CoreBusy;
  logic [DW-1:0] CoreData;

  logic          DmaReq;
  logic          DmaWr;
  logic [AW-1:0] DmaAddr;
  logic [DW-1:0] DmaWrData;
  logic          DmaGnt;
  logic          DmaRdValid;
  logic [DW-1:0] DmaRdData;

  logic [AW-1:0] IRam1Addr;
  logic          IRam1En;
  logic          IRam1Wr;
  logic [DW-1:0] IRam1WrData;
  logic          IRam1LoadStore;
  logic [DW-1:0] IRam1Data;

  modport slave (
    input  CoreEn, CoreWr, CoreAddr, CoreWrData, CoreLoadStore,
    output CoreBusy, CoreData,
    input  DmaReq, DmaWr, DmaAddr, DmaWrData,
    output DmaGnt, DmaRdValid, DmaRdData,
    output IRam1Addr, IRam1En, IRam1Wr, IRam1WrData, IRam1LoadStore,
    input  IRam1Data
  );

  modport master (
    output CoreEn, CoreWr, CoreAddr, CoreWrData, CoreLoadStore,
    input  CoreBusy, CoreData,
    output DmaReq, DmaWr, DmaAddr, DmaWrData,
    input  DmaGnt, DmaRdValid, DmaRdData,
    input  IRam1Addr, IRam1En, IRam1Wr, IRam1WrData, IRam1LoadStore,
    output IRam1Data
  );
endinterface

// File: rtl/peregrine_iram1_arb.sv
// IRAM1 arbiter: core has fixed priority over the DMA/preload port; a
// starvation counter forces one DMA slot after STARVE_LIMIT consecutive
// denied DMA cycles. Read data (1-cycle latency) is passed through to both
// requesters; DmaRdValid marks the cycle that belongs to a DMA read.
// Ports:
//   CLK      clock, all state on posedge
//   Reset_n  synchronous active-low reset
//   bus      peregrine_iram1_arb_if.slave (core, DMA and memory signals)
module peregrine_iram1_arb #(
  parameter int AW           = 17,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  peregrine_iram1_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  logic [7:0]    starve_q, starve_d;
  owner_e        rd_owner_q, rd_owner_d;

  logic          force_dma;
  logic          dma_win;
  logic          core_win;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic          mem_ls;

  always_comb begin
    force_dma = bus.DmaReq && (starve_q >= 8'(STARVE_LIMIT));
    // Grants are suppressed while reset is held so the memory sees no access.
    dma_win   = Reset_n && bus.DmaReq && (force_dma || !bus.CoreEn);
    core_win  = Reset_n && bus.CoreEn && !dma_win;

    // Idle cycles keep the core address/data on the pins.
    mem_addr  = bus.CoreAddr;
    mem_wdata = bus.CoreWrData;
    mem_wr    = 1'b0;
    mem_ls    = 1'b0;
    if (dma_win) begin
      mem_addr  = bus.DmaAddr;
      mem_wdata = bus.DmaWrData;
      mem_wr    = bus.DmaWr;
    end else if (core_win) begin
      mem_wr    = bus.CoreWr;
      mem_ls    = bus.CoreLoadStore;
    end

    starve_d = starve_q;
    if (!bus.DmaReq || dma_win) begin
      starve_d = '0;
    end else if (starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end

    rd_owner_d = OWN_NONE;
    if (dma_win && !bus.DmaWr) begin
      rd_owner_d = OWN_DMA;
    end else if (core_win && !bus.CoreWr) begin
      rd_owner_d = OWN_CORE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      starve_q   <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.DmaGnt         = dma_win;
  assign bus.CoreBusy       = bus.CoreEn && dma_win;
  assign bus.IRam1En        = core_win || dma_win;
  assign bus.IRam1Addr      = mem_addr;
  assign bus.IRam1Wr        = mem_wr;
  assign bus.IRam1WrData    = mem_wdata;
  assign bus.IRam1LoadStore = mem_ls;

  // Gated with Reset_n so a read granted just before reset asserts never
  // reports a response once the requester has been reset.
  assign bus.DmaRdValid     = Reset_n && (rd_owner_q == OWN_DMA);
  assign bus.DmaRdData      = bus.IRam1Data;
  assign bus.CoreData       = bus.IRam1Data;

endmodule

// File: tb/tb_peregrine_iram1_arb.sv
module tb_peregrine_iram1_arb;
  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic CLK = 1'b0;
  logic Reset_n;
  always #5 CLK = ~CLK;

  peregrine_iram1_arb_if #(.AW(AW), .DW(DW)) bus ();

  peregrine_iram1_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Behavioural single-port IRAM1 with 1-cycle read latency.
  logic [DW-1:0] mem [logic [AW-1:0]];
  always @(posedge CLK) begin
    if (bus.IRam1En) begin
      if (bus.IRam1Wr) mem[bus.IRam1Addr] = bus.IRam1WrData;
      else bus.IRam1Data <= mem.exists(bus.IRam1Addr) ? mem[bus.IRam1Addr] : 32'h0BAD0BAD;
    end
  end

  int tests_run = 0;
  int failed    = 0;
  logic [DW-1:0] core_q[$];
  logic [DW-1:0] dma_q[$];
  logic [DW-1:0] exp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs just after posedge, return at the following negedge.
  task automatic drive(input logic rst, input logic ce, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic cls, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(posedge CLK); #1;
    Reset_n = rst;
    bus.CoreEn = ce; bus.CoreWr = cw; bus.CoreAddr = ca; bus.CoreWrData = cd; bus.CoreLoadStore = cls;
    bus.DmaReq = dr; bus.DmaWr = dw; bus.DmaAddr = da; bus.DmaWrData = dd;
    @(negedge CLK);
  endtask

  task automatic idle();
    drive(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      drive(0, 1, 1, 17'h00055, 32'h1, 1, 1, 1, 17'h00066, 32'h2);
      tests_run++; if (bus.DmaGnt !== 1'b0) begin failed++; $display("FAIL rst_gnt: got %b want 0", bus.DmaGnt); end
      tests_run++; if (bus.CoreBusy !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b want 0", bus.CoreBusy); end
      tests_run++; if (bus.IRam1En !== 1'b0) begin failed++; $display("FAIL rst_en: got %b want 0", bus.IRam1En); end
      tests_run++; if (bus.IRam1Wr !== 1'b0) begin failed++; $display("FAIL rst_wr: got %b want 0", bus.IRam1Wr); end
      tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL rst_rdvalid: got %b want 0", bus.DmaRdValid); end
    end
    idle();
  endtask

  task automatic test_dma_only();
    drive(1, 0, 0, '0, '0, 0, 1, 1, 17'h1F000, 32'h12345678);
    tests_run++; if (bus.DmaGnt !== 1'b1) begin failed++; $display("FAIL dma_wr_gnt: got %b want 1", bus.DmaGnt); end
    tests_run++; if (bus.IRam1En !== 1'b1 || bus.IRam1Wr !== 1'b1) begin failed++; $display("FAIL dma_wr_pins: got en=%b wr=%b want 1 1", bus.IRam1En, bus.IRam1Wr); end
    tests_run++; if (bus.IRam1Addr !== 17'h1F000 || bus.IRam1WrData !== 32'h12345678) begin failed++; $display("FAIL dma_wr_addr: got %h/%h want 1f000/12345678", bus.IRam1Addr, bus.IRam1WrData); end
    tests_run++; if (bus.IRam1LoadStore !== 1'b0) begin failed++; $display("FAIL dma_wr_ls: got %b want 0", bus.IRam1LoadStore); end
    drive(1, 0, 0, '0, '0, 0, 1, 1, 17'h00010, 32'hDEADBEEF);
    tests_run++; if (bus.DmaGnt !== 1'b1) begin failed++; $display("FAIL dma_wr2_gnt: got %b want 1", bus.DmaGnt); end
    tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL dma_wr_noresp: got %b want 0", bus.DmaRdValid); end
    drive(1, 0, 0, '0, '0, 0, 1, 0, 17'h1F000, '0);
    dma_q.push_back(32'h12345678);
    tests_run++; if (bus.DmaGnt !== 1'b1) begin failed++; $display("FAIL dma_rd_gnt: got %b want 1", bus.DmaGnt); end
    tests_run++; if (bus.IRam1Wr !== 1'b0 || bus.IRam1LoadStore !== 1'b0) begin failed++; $display("FAIL dma_rd_pins: got wr=%b ls=%b want 0 0", bus.IRam1Wr, bus.IRam1LoadStore); end
    tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL dma_rd_early: got %b want 0", bus.DmaRdValid); end
    idle();
    tests_run++; if (bus.DmaRdValid !== 1'b1) begin failed++; $display("FAIL dma_rd_valid: got %b want 1", bus.DmaRdValid); end
    exp = dma_q.pop_front();
    tests_run++; if (bus.DmaRdData !== exp) begin failed++; $display("FAIL dma_rd_data: got %h want %h", bus.DmaRdData, exp); end
    idle();
    tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL dma_rd_once: got %b want 0", bus.DmaRdValid); end
  endtask

  task automatic test_core_only();
    drive(1, 1, 0, 17'h00010, '0, 1, 0, 0, '0, '0);
    core_q.push_back(32'hDEADBEEF);
    tests_run++; if (bus.CoreBusy !== 1'b0) begin failed++; $display("FAIL core_busy0: got %b want 0", bus.CoreBusy); end
    tests_run++; if (bus.IRam1En !== 1'b1 || bus.IRam1Wr !== 1'b0 || bus.IRam1Addr !== 17'h00010) begin failed++; $display("FAIL core_rd_pins: got en=%b wr=%b a=%h want 1 0 00010", bus.IRam1En, bus.IRam1Wr, bus.IRam1Addr); end
    tests_run++; if (bus.IRam1LoadStore !== 1'b1) begin failed++; $display("FAIL core_ls1: got %b want 1", bus.IRam1LoadStore); end
    drive(1, 1, 1, 17'h00020, 32'hA5A50001, 1, 0, 0, '0, '0);
    exp = core_q.pop_front();
    tests_run++; if (bus.CoreData !== exp) begin failed++; $display("FAIL core_rd_data: got %h want %h", bus.CoreData, exp); end
    tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL core_no_dmavalid: got %b want 0", bus.DmaRdValid); end
    tests_run++; if (bus.CoreBusy !== 1'b0 || bus.IRam1Wr !== 1'b1) begin failed++; $display("FAIL core_wr: got busy=%b wr=%b want 0 1", bus.CoreBusy, bus.IRam1Wr); end
    drive(1, 1, 0, 17'h00020, '0, 0, 0, 0, '0, '0);
    core_q.push_back(32'hA5A50001);
    tests_run++; if (bus.IRam1LoadStore !== 1'b0) begin failed++; $display("FAIL core_ls0: got %b want 0", bus.IRam1LoadStore); end
    idle();
    exp = core_q.pop_front();
    tests_run++; if (bus.CoreData !== exp) begin failed++; $display("FAIL core_wr_then_rd: got %h want %h", bus.CoreData, exp); end
    tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL core_no_dmavalid2: got %b want 0", bus.DmaRdValid); end
  endtask

  task automatic test_contention();
    int unsigned core_grants = 0;
    logic exp_g;
    for (int unsigned i = 1; i <= 27; i++) begin
      drive(1, 1, 0, 17'h00010, '0, 0, 1, 1, 17'h00030, 32'(i));
      exp_g = ((i % (LIM + 1)) == 0);
      tests_run++; if (bus.DmaGnt !== exp_g || bus.CoreBusy !== exp_g) begin failed++; $display("FAIL contention_c%0d: got gnt=%b busy=%b want %b %b", i, bus.DmaGnt, bus.CoreBusy, exp_g, exp_g); end
      tests_run++; if (bus.IRam1Addr !== (exp_g ? 17'h00030 : 17'h00010)) begin failed++; $display("FAIL contention_addr_c%0d: got %h want %h", i, bus.IRam1Addr, exp_g ? 17'h00030 : 17'h00010); end
      if (!bus.CoreBusy && bus.IRam1En) core_grants++;
    end
    tests_run++; if (core_grants != 24) begin failed++; $display("FAIL contention_core_grants: got %0d want 24", core_grants); end
    idle();
  endtask

  task automatic test_alternating();
    for (int unsigned i = 1; i <= 7; i++) begin
      drive(1, 1, 1, 17'h00040, 32'(i), 0, 1, 0, 17'h1F000, '0);
      tests_run++; if (bus.DmaGnt !== 1'b0) begin failed++; $display("FAIL alt_denied_c%0d: got %b want 0", i, bus.DmaGnt); end
    end
    drive(1, 1, 0, 17'h00010, '0, 1, 1, 0, 17'h1F000, '0);
    core_q.push_back(32'hDEADBEEF);
    tests_run++; if (bus.DmaGnt !== 1'b0 || bus.CoreBusy !== 1'b0) begin failed++; $display("FAIL alt_core_win: got gnt=%b busy=%b want 0 0", bus.DmaGnt, bus.CoreBusy); end
    drive(1, 1, 0, 17'h00010, '0, 1, 1, 0, 17'h1F000, '0);
    dma_q.push_back(32'h12345678);
    tests_run++; if (bus.DmaGnt !== 1'b1 || bus.CoreBusy !== 1'b1) begin failed++; $display("FAIL alt_forced: got gnt=%b busy=%b want 1 1", bus.DmaGnt, bus.CoreBusy); end
    exp = core_q.pop_front();
    tests_run++; if (bus.CoreData !== exp) begin failed++; $display("FAIL alt_core_data: got %h want %h", bus.CoreData, exp); end
    tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL alt_no_early_valid: got %b want 0", bus.DmaRdValid); end
    idle();
    exp = dma_q.pop_front();
    tests_run++; if (bus.DmaRdValid !== 1'b1 || bus.DmaRdData !== exp) begin failed++; $display("FAIL alt_dma_data: got v=%b d=%h want 1 %h", bus.DmaRdValid, bus.DmaRdData, exp); end
    idle();
    tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL alt_valid_once: got %b want 0", bus.DmaRdValid); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, '0, '0, 0, 1, 0, 17'h1F000, '0);
    tests_run++; if (bus.DmaGnt !== 1'b1) begin failed++; $display("FAIL rmid_gnt: got %b want 1", bus.DmaGnt); end
    for (int unsigned i = 0; i < 2; i++) begin
      drive(0, 1, 0, 17'h00010, '0, 0, 1, 0, 17'h1F000, '0);
      tests_run++; if (bus.DmaRdValid !== 1'b0) begin failed++; $display("FAIL rmid_valid_%0d: got %b want 0", i, bus.DmaRdValid); end
      tests_run++; if (bus.IRam1En !== 1'b0 || bus.DmaGnt !== 1'b0 || bus.CoreBusy !== 1'b0) begin failed++; $display("FAIL rmid_quiet_%0d: got en=%b gnt=%b busy=%b want 0 0 0", i, bus.IRam1En, bus.DmaGnt, bus.CoreBusy); end
    end
    for (int unsigned i = 1; i <= 9; i++) begin
      drive(1, 1, 0, 17'h00010, '0, 0, 1, 0, 17'h1F000, '0);
      tests_run++; if (bus.DmaGnt !== (i == 9)) begin failed++; $display("FAIL rmid_after_c%0d: got %b want %b", i, bus.DmaGnt, (i == 9)); end
    end
    idle();
    idle();
  endtask

  task automatic test_drop_restart();
    for (int unsigned i = 1; i <= 5; i++) begin
      drive(1, 1, 0, 17'h00010, '0, 0, 1, 0, 17'h1F000, '0);
      tests_run++; if (bus.DmaGnt !== 1'b0) begin failed++; $display("FAIL drop_pre_c%0d: got %b want 0", i, bus.DmaGnt); end
    end
    drive(1, 1, 0, 17'h00010, '0, 0, 0, 0, '0, '0);
    tests_run++; if (bus.DmaGnt !== 1'b0 || bus.CoreBusy !== 1'b0) begin failed++; $display("FAIL drop_gap: got gnt=%b busy=%b want 0 0", bus.DmaGnt, bus.CoreBusy); end
    for (int unsigned i = 1; i <= 9; i++) begin
      drive(1, 1, 0, 17'h00010, '0, 0, 1, 0, 17'h1F000, '0);
      tests_run++; if (bus.DmaGnt !== (i == 9)) begin failed++; $display("FAIL drop_post_c%0d: got %b want %b", i, bus.DmaGnt, (i == 9)); end
    end
    idle();
    idle();
  endtask

  initial begin
    Reset_n = 1'b0;
    bus.CoreEn = 0; bus.CoreWr = 0; bus.CoreAddr = '0; bus.CoreWrData = '0; bus.CoreLoadStore = 0;
    bus.DmaReq = 0; bus.DmaWr = 0; bus.DmaAddr = '0; bus.DmaWrData = '0;
    test_reset();
    test_dma_only();
    test_core_only();
    test_contention();
    test_alternating();
    test_reset_mid();
    test_drop_restart();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
